// File: rtl/flag_status_unit.sv
// Condition-flag producer: Z/N/C capture, pending/architectural
// registers, decode forwarding, branch hazard detection, shadow copy.
module flag_status_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic [2:0]            ex_flag_mask,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  ex_carry_out,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  save_flags,
    input  logic                  restore_flags,
    input  logic [7:0]            id_operation,
    output logic [2:0]            flags_out,
    output logic                  hazard_stall,
    output logic [2:0]            shadow_flags
);

    logic [2:0] ex_flags;
    logic       capture;
    logic [2:0] flag_reg;
    logic [2:0] shadow;
    logic       pend_valid;
    logic [2:0] pend_mask;
    logic [2:0] pend_flags;
    logic [2:0] fwd_sel;
    logic       is_cond_br;
    logic       tested_hit;

    assign ex_flags[0] = (ex_result == '0);
    assign ex_flags[1] = ex_result[DATA_WIDTH-1];
    assign ex_flags[2] = ex_carry_out;

    assign capture = ex_valid && (|ex_flag_mask)
                  && !stall && !flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flag_reg   <= 3'b000;
            pend_valid <= 1'b0;
            pend_mask  <= 3'b000;
            pend_flags <= 3'b000;
        end else if (restore_flags) begin
            flag_reg   <= shadow;
            pend_valid <= 1'b0;
        end else begin
            // The pending entry is older, so it commits regardless of stall/flush.
            if (pend_valid)
                flag_reg <= (flag_reg & ~pend_mask)
                          | (pend_flags & pend_mask);
            pend_valid <= capture;
            if (capture) begin
                pend_mask  <= ex_flag_mask;
                pend_flags <= ex_flags;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            shadow <= 3'b000;
        else if (save_flags && !restore_flags)
            shadow <= flags_out;
    end

    assign fwd_sel   = pend_valid ? pend_mask : 3'b000;
    assign flags_out = (flag_reg & ~fwd_sel)
                     | (pend_flags & fwd_sel);

    assign shadow_flags = shadow;

    assign is_cond_br = (id_operation[7:3] == 5'b00111)
                     && (id_operation[1:0] != 2'b00);

    always_comb begin
        tested_hit = 1'b0;
        unique case (id_operation[1:0])
            2'b01:   tested_hit = ex_flag_mask[2];
            2'b10:   tested_hit = ex_flag_mask[0];
            2'b11:   tested_hit = ex_flag_mask[1];
            default: tested_hit = 1'b0;
        endcase
    end

    assign hazard_stall = is_cond_br && ex_valid && tested_hit;

endmodule

// File: tb/tb_flag_status_unit.sv
// Bench for flag_status_unit: directed steps plus random traffic
// against a model that tracks only the visible flags and shadow.
module tb_flag_status_unit;

    localparam int W = 8;

    logic         clock;
    logic         reset_n;
    logic         ex_valid;
    logic [2:0]   ex_flag_mask;
    logic [W-1:0] ex_result;
    logic         ex_carry_out;
    logic         stall;
    logic         flush;
    logic         save_flags;
    logic         restore_flags;
    logic [7:0]   id_operation;
    logic [2:0]   flags_out;
    logic         hazard_stall;
    logic [2:0]   shadow_flags;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] m_vis;
    logic [2:0] m_shadow;

    flag_status_unit #(.DATA_WIDTH(W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_flag_mask  (ex_flag_mask),
        .ex_result     (ex_result),
        .ex_carry_out  (ex_carry_out),
        .stall         (stall),
        .flush         (flush),
        .save_flags    (save_flags),
        .restore_flags (restore_flags),
        .id_operation  (id_operation),
        .flags_out     (flags_out),
        .hazard_stall  (hazard_stall),
        .shadow_flags  (shadow_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [3:0] obs,
                       input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    function automatic logic model_hazard();
        logic [7:0] op;
        int idx;
        op = id_operation;
        if (op[7:3] != 5'b00111 || op[1:0] == 2'b00)
            return 1'b0;
        case (op[1:0])
            2'b01:   idx = 2;
            2'b10:   idx = 0;
            default: idx = 1;
        endcase
        return ex_valid && ex_flag_mask[idx];
    endfunction

    task automatic drive(input logic v, input logic [2:0] m,
                         input logic [W-1:0] r, input logic c);
        ex_valid     = v;
        ex_flag_mask = m;
        ex_result    = r;
        ex_carry_out = c;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, '0, 1'b0);
        stall = 0; flush = 0;
        save_flags = 0; restore_flags = 0;
        id_operation = 8'h00;
    endtask

    // One cycle: check outputs mid-cycle, then advance the model on the edge.
    task automatic cyc();
        logic       cap;
        logic [2:0] newf;
        logic [2:0] sh_next;
        @(negedge clock);
        chk("hazard", {3'b0, hazard_stall}, {3'b0, model_hazard()});
        chk("flags_out", {1'b0, flags_out}, {1'b0, m_vis});
        chk("shadow", {1'b0, shadow_flags}, {1'b0, m_shadow});
        @(posedge clock);
        cap = ex_valid && (ex_flag_mask != 0) && !stall && !flush;
        newf = {ex_carry_out, ex_result[W-1], ex_result == 0};
        sh_next = m_shadow;
        if (save_flags && !restore_flags)
            sh_next = m_vis;
        if (restore_flags)
            m_vis = m_shadow;
        else if (cap)
            m_vis = (m_vis & ~ex_flag_mask) | (newf & ex_flag_mask);
        m_shadow = sh_next;
        #1;
    endtask

    initial begin
        m_vis = 3'b000;
        m_shadow = 3'b000;
        reset_n = 1'b0;
        idle();
        #2;
        chk("rst_flags", {1'b0, flags_out}, 4'h0);
        chk("rst_shadow", {1'b0, shadow_flags}, 4'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        drive(1'b1, 3'b001, 8'h00, 1'b0);
        cyc();
        idle();
        #1 chk("z_fwd", {1'b0, flags_out}, 4'h1);
        cyc();
        cyc();
        chk("z_commit", {1'b0, flags_out}, 4'h1);

        drive(1'b1, 3'b110, 8'h80, 1'b1);
        cyc();
        idle();
        #1 chk("nc_merge", {1'b0, flags_out}, 4'h7);
        cyc();

        id_operation = 8'b00111110;
        drive(1'b1, 3'b001, 8'h00, 1'b0);
        stall = 1;
        #1 chk("hz_z", {3'b0, hazard_stall}, 4'h1);
        ex_flag_mask = 3'b100;
        #1 chk("hz_c_only", {3'b0, hazard_stall}, 4'h0);
        id_operation = 8'b00111000;
        ex_flag_mask = 3'b111;
        #1 chk("hz_uncond", {3'b0, hazard_stall}, 4'h0);
        cyc();
        idle();

        drive(1'b1, 3'b001, 8'h01, 1'b0);
        flush = 1;
        cyc();
        idle();
        cyc();
        chk("flush_keep", {1'b0, flags_out}, 4'h7);

        drive(1'b1, 3'b001, 8'h01, 1'b0);
        stall = 1;
        repeat (3) cyc();
        chk("stall_hold", {1'b0, flags_out}, 4'h7);
        stall = 0;
        cyc();
        idle();
        #1 chk("stall_rel", {1'b0, flags_out}, 4'h6);
        cyc();

        drive(1'b1, 3'b111, 8'h00, 1'b1);
        cyc();
        idle();
        save_flags = 1;
        cyc();
        idle();
        #1 chk("saved", {1'b0, shadow_flags}, 4'h5);
        drive(1'b1, 3'b111, 8'h80, 1'b0);
        cyc();
        chk("pend_010", {1'b0, flags_out}, 4'h2);
        drive(1'b1, 3'b111, 8'h80, 1'b1);
        restore_flags = 1;
        save_flags = 1;
        cyc();
        idle();
        #1 chk("restored", {1'b0, flags_out}, 4'h5);
        chk("restore_sh", {1'b0, shadow_flags}, 4'h5);
        cyc();

        drive(1'b1, 3'b111, 8'h80, 1'b0);
        cyc();
        idle();
        #2 reset_n = 1'b0;
        #1 chk("arst_flags", {1'b0, flags_out}, 4'h0);
        chk("arst_shadow", {1'b0, shadow_flags}, 4'h0);
        m_vis = 3'b000;
        m_shadow = 3'b000;
        @(posedge clock); #1;
        reset_n = 1'b1;
        cyc();
        drive(1'b1, 3'b001, 8'h00, 1'b0);
        cyc();
        idle();
        #1 chk("post_rst", {1'b0, flags_out}, 4'h1);
        cyc();

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  3'($urandom),
                  ($urandom_range(0, 3) == 0) ? '0 : W'($urandom),
                  1'($urandom));
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            save_flags = ($urandom_range(0, 9) == 0);
            restore_flags = ($urandom_range(0, 11) == 0);
            id_operation = ($urandom_range(0, 1) != 0)
                         ? {5'b00111, 3'($urandom)}
                         : 8'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
